// File: rtl/aes_edn_responder.sv
// aes_edn_responder: packs raw entropy chunks, health-checks repeats, buffers words and serves them on req/ack.
// Optional: define AES_EDN_RSP_DATA_MASK_EN to hide entropy_o outside of an ack cycle.
module aes_edn_responder #(
    parameter int unsigned SrcWidth     = 16,
    parameter int unsigned EntropyWidth = 32,
    parameter int unsigned Depth        = 4,
    parameter int unsigned RepLimit     = 3,
    parameter int unsigned StarveLimit  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     src_valid_i,
    input  logic [SrcWidth-1:0]      src_data_i,
    output logic                     src_ready_o,
    input  logic                     entropy_req_i,
    output logic                     entropy_ack_o,
    output logic [EntropyWidth-1:0]  entropy_o,
    input  logic                     clear_i,
    output logic                     alert_o,
    output logic                     starve_o,
    output logic [$clog2(Depth):0]   level_o
);
    localparam int unsigned Chunks = EntropyWidth / SrcWidth;
    localparam int unsigned AW     = $clog2(Depth);
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned CW     = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int unsigned RW     = $clog2(RepLimit + 1);
    localparam int unsigned SW     = $clog2(StarveLimit + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, STARVED} state_e;

    logic [EntropyWidth-1:0] pack_q, pack_d, word_q, prev_q, head;
    logic [EntropyWidth-1:0] mem_q [Depth];
    logic [CW-1:0]           chunk_q;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [LW-1:0]           count_q;
    logic [RW-1:0]           rep_q;
    logic [SW-1:0]           starve_cnt_q, starve_cnt_d;
    logic                    word_vld_q, prev_vld_q, alert_q, starve_q;
    logic                    accept, last, repeat_w, push, empty, ack;
    state_e                  state_q;

    assign accept   = src_valid_i & src_ready_o;
    assign last     = chunk_q == CW'(Chunks - 1);
    assign repeat_w = word_vld_q & prev_vld_q & (word_q == prev_q);
    assign push     = word_vld_q & ~repeat_w;
    assign empty    = count_q == '0;
    assign head     = mem_q[rptr_q];
    assign ack      = entropy_req_i & ~empty & ~alert_q & ~rst_i;

    // a pending packed word counts against capacity so it always has a slot
    assign src_ready_o   = ~rst_i & ~alert_q & ((count_q + LW'(word_vld_q)) < LW'(Depth));
    assign entropy_ack_o = ack;
    assign alert_o       = alert_q;
    assign starve_o      = starve_q;
    assign level_o       = count_q;
`ifdef AES_EDN_RSP_DATA_MASK_EN
    assign entropy_o = ack ? head : '0;
`else
    assign entropy_o = empty ? '0 : head;
`endif

    always_comb begin
        pack_d = pack_q;
        pack_d[32'(chunk_q) * SrcWidth +: SrcWidth] = src_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pack_q     <= '0;
            word_q     <= '0;
            chunk_q    <= '0;
            word_vld_q <= 1'b0;
        end else begin
            word_vld_q <= 1'b0;
            if (accept) begin
                pack_q  <= pack_d;
                chunk_q <= last ? '0 : chunk_q + CW'(1);
                if (last) begin
                    word_q     <= pack_d;
                    word_vld_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= word_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rep_q      <= '0;
            alert_q    <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (ack) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + LW'(push) - LW'(ack);
            if (repeat_w) begin
                if (rep_q == RW'(RepLimit - 1)) alert_q <= 1'b1;
                else rep_q <= rep_q + RW'(1);
            end else if (push) begin
                prev_q     <= word_q;
                prev_vld_q <= 1'b1;
                rep_q      <= '0;
            end
            if (clear_i) begin
                alert_q    <= 1'b0;
                prev_vld_q <= 1'b0;
                rep_q      <= '0;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) assert (!(push && count_q == LW'(Depth)));
    end

    // entering STARVED counts as the first starved cycle
    always_comb starve_cnt_d = (state_q != STARVED) ? SW'(1) :
                               (starve_cnt_q == SW'(StarveLimit)) ? starve_cnt_q : starve_cnt_q + SW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            state_q      <= !entropy_req_i ? IDLE : (empty ? STARVED : ACTIVE);
            starve_cnt_q <= (entropy_req_i & empty) ? starve_cnt_d : '0;
            if (entropy_req_i & empty & (starve_cnt_d == SW'(StarveLimit))) starve_q <= 1'b1;
            if (clear_i) starve_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_edn_responder.sv
// tb_aes_edn_responder: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_aes_edn_responder;
    localparam int DEPTH  = 4;
    localparam int REP    = 3;
    localparam int STARVE = 64;

    logic        clk = 1'b0, rst = 1'b1, src_valid = 1'b0, entropy_req = 1'b0, clear = 1'b0;
    logic [15:0] src_data = '0;
    logic        src_ready, entropy_ack, alert, starve;
    logic [31:0] entropy;
    logic [2:0]  level;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    logic [31:0] mq[$];
    logic [15:0] mch[$];
    logic [31:0] mpend, mprev;
    bit          mpend_v, mprev_v, malert, mstarve;
    int          mrep, mscnt;

    logic [31:0] wl[4];
    logic [15:0] pool[3];

    always #5 clk = ~clk;

    aes_edn_responder dut (
        .clk_i(clk), .rst_i(rst), .src_valid_i(src_valid), .src_data_i(src_data),
        .src_ready_o(src_ready), .entropy_req_i(entropy_req), .entropy_ack_o(entropy_ack),
        .entropy_o(entropy), .clear_i(clear), .alert_o(alert), .starve_o(starve), .level_o(level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: words are queues of chunks, the FIFO is a queue of words
    always @(posedge clk) begin : model
        bit was_empty, m_ack, m_rdy;
        if (rst) begin
            mq.delete(); mch.delete();
            mpend_v = 0; mprev_v = 0; malert = 0; mstarve = 0; mrep = 0; mscnt = 0;
        end else begin
            was_empty = mq.size() == 0;
            m_ack = entropy_req && !was_empty && !malert;
            m_rdy = !malert && (mq.size() + int'(mpend_v) < DEPTH);
            if (entropy_req && was_empty) begin
                mscnt++;
                if (mscnt >= STARVE) mstarve = 1;
            end else mscnt = 0;
            if (m_ack) void'(mq.pop_front());
            if (mpend_v) begin
                if (mprev_v && mpend == mprev) begin
                    mrep++;
                    if (mrep >= REP) malert = 1;
                end else begin
                    mq.push_back(mpend);
                    mprev = mpend; mprev_v = 1; mrep = 0;
                end
            end
            mpend_v = 0;
            if (src_valid && m_rdy) begin
                mch.push_back(src_data);
                if (mch.size() == 2) begin
                    mpend = {mch[1], mch[0]};
                    mpend_v = 1;
                    mch.delete();
                end
            end
            if (clear) begin
                malert = 0; mstarve = 0; mrep = 0; mprev_v = 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit e_empty, e_ack, e_rdy;
        logic [31:0] e_data;
        if (chk_en) begin
            e_empty = mq.size() == 0;
            e_ack = !rst && entropy_req && !e_empty && !malert;
            e_rdy = !rst && !malert && (mq.size() + int'(mpend_v) < DEPTH);
            e_data = '0;
`ifdef AES_EDN_RSP_DATA_MASK_EN
            if (e_ack) e_data = mq[0];
`else
            if (!e_empty) e_data = mq[0];
`endif
            chk("m_ack", 32'(entropy_ack), 32'(e_ack));
            chk("m_entropy", entropy, e_data);
            chk("m_ready", 32'(src_ready), 32'(e_rdy));
            chk("m_alert", 32'(alert), 32'(malert));
            chk("m_starve", 32'(starve), 32'(mstarve));
            chk("m_level", 32'(level), 32'(mq.size()));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic feed(input logic [15:0] d);
        bit acc;
        acc = 0;
        src_valid = 1; src_data = d;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk); acc = src_ready;
            @(posedge clk); #2;
        end
        src_valid = 0;
        chk("feed_accepted", 32'(acc), 32'd1);
    endtask

    task automatic feed_word(input logic [31:0] w);
        feed(w[15:0]);
        feed(w[31:16]);
    endtask

    task automatic wait_ack(input string name, input logic [31:0] exp, input int exp_lvl);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (entropy_ack) begin
                got = 1;
                chk(name, entropy, exp);
                chk({name, "_level"}, 32'(level), 32'(exp_lvl));
            end
            @(posedge clk); #2;
        end
        chk({name, "_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int n, ph;
        wl[0] = 32'hA0A0_0001; wl[1] = 32'hB0B0_0002; wl[2] = 32'hC0C0_0003; wl[3] = 32'hD0D0_0004;
        pool[0] = 16'h1111; pool[1] = 16'h2222; pool[2] = 16'h3333;
        @(posedge clk); #2; chk_en = 1;
        @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_entropy", entropy, 0);
        chk("rst_ack", 32'(entropy_ack), 0);
        chk("rst_ready", 32'(src_ready), 0);
        chk("rst_alert", 32'(alert), 0);
        chk("rst_starve", 32'(starve), 0);
        @(posedge clk); #2; rst = 0;
        // basic packing and serving
        entropy_req = 1;
        feed_word(32'h2222_1111);
        wait_ack("pack1", 32'h2222_1111, 1);
        feed_word(32'h4444_3333);
        wait_ack("pack2", 32'h4444_3333, 1);
        @(negedge clk); chk("drained_level", 32'(level), 0);
        @(posedge clk); #2; entropy_req = 0;
        // fill to capacity, then burst out
        for (int i = 0; i < 4; i++) feed_word(wl[i]);
        step(2);
        @(negedge clk);
        chk("full_level", 32'(level), 4);
        chk("full_ready", 32'(src_ready), 0);
`ifdef AES_EDN_RSP_DATA_MASK_EN
        chk("head_masked", entropy, 0);
`else
        chk("head_visible", entropy, wl[0]);
`endif
        @(posedge clk); #2; entropy_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("burst_ack", 32'(entropy_ack), 1);
            chk("burst_data", entropy, wl[i]);
            @(posedge clk); #2;
        end
        entropy_req = 0;
        @(negedge clk); chk("burst_level", 32'(level), 0);
        @(posedge clk); #2;
        // repetition alert and clear
        repeat (4) feed_word(32'hDEAD_BEEF);
        step(2);
        @(negedge clk);
        chk("rep_alert", 32'(alert), 1);
        chk("rep_level", 32'(level), 1);
        chk("rep_ready", 32'(src_ready), 0);
        @(posedge clk); #2; entropy_req = 1;
        repeat (3) begin
            @(negedge clk); chk("alert_blocks_ack", 32'(entropy_ack), 0);
            @(posedge clk); #2;
        end
        clear = 1; step(1); clear = 0;
        wait_ack("after_clear", 32'hDEAD_BEEF, 1);
        entropy_req = 0;
        @(negedge clk); chk("cleared_alert", 32'(alert), 0);
        @(posedge clk); #2;
        // starvation
        entropy_req = 1; n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (starve) break;
            n++;
        end
        chk("starve_cycles", 32'(n), 32'd64);
        @(posedge clk); #2;
        feed_word(32'h5555_AAAA);
        wait_ack("starve_word", 32'h5555_AAAA, 1);
        entropy_req = 0; clear = 1; step(1); clear = 0;
        @(negedge clk); chk("starve_cleared", 32'(starve), 0);
        @(posedge clk); #2;
        // request dropped after one of two words
        feed_word(32'h1357_2468);
        feed_word(32'h0BAD_F00D);
        step(2);
        entropy_req = 1;
        wait_ack("partial1", 32'h1357_2468, 2);
        entropy_req = 0;
        step(2);
        @(negedge clk);
        chk("partial_level", 32'(level), 1);
        chk("partial_noack", 32'(entropy_ack), 0);
        @(posedge clk); #2; entropy_req = 1;
        wait_ack("partial2", 32'h0BAD_F00D, 1);
        entropy_req = 0;
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            ph = (c / 500) % 4;
            src_valid = (ph == 3) ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 3) < ((ph == 1) ? 1 : 3));
            src_data = (ph == 2) ? 16'($urandom) : pool[$urandom_range(0, 2)];
            entropy_req = (ph == 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            clear = $urandom_range(0, 39) == 0;
            rst = $urandom_range(0, 999) == 0;
            @(posedge clk); #2;
        end
        rst = 0; clear = 0; entropy_req = 0; src_valid = 0;
        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
